piso_serializer: RTL and testbench

- Parallel-in serial-out stage that sits directly downstream of the n-bit parallel register.
- Captures the register's Q word through a valid/ready handshake and shifts it out one bit per enabled clock.
- Bit order is selectable by parameter.
- Supports gapless back-to-back words and a stall input for slow consumers.

---
 rtl/piso_serializer.sv | 101 ++++++++++
 tb/tb_piso_serializer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter
// valid/ready word capture, stallable one-bit-per-cycle output
module piso_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  sr;
  logic [N-1:0]  sr_shifted;
  logic [CW-1:0] cnt;
  logic          last;
  logic          xfer;

  assign last = (state == SHIFT) && (cnt == LAST);
  assign xfer = load_valid && load_ready;
  assign sout = MSB_FIRST ? sr[N-1] : sr[0];

  assign sr_shifted = MSB_FIRST ? {sr[N-2:0], 1'b0}
                                : {1'b0, sr[N-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: leave SHIFT only when the last bit goes with no new word
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (xfer) state_nx = SHIFT;
      end
      SHIFT: begin
        if (last && shift_en && !xfer) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: handshake, valid and completion flags
  always_comb begin
    load_ready = 1'b0;
    done       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        busy       = 1'b1;
        sout_valid = shift_en;
        done       = last && shift_en;
        load_ready = last && shift_en;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  // Datapath: capture word, shift toward output end, count bits
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (xfer) begin
      sr  <= din;
      cnt <= '0;
    end else if ((state == SHIFT) && shift_en) begin
      sr  <= sr_shifted;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed + random checks of both bit orders
// against a queue-of-pending-bits reference model
module tb_piso_serializer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] din;
  logic         load_valid;
  logic         shift_en;

  logic m_lr, m_so, m_sv, m_busy, m_done;
  logic l_lr, l_so, l_sv, l_busy, l_done;

  int total = 0;
  int bad   = 0;
  int dones = 0;

  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  piso_serializer #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (m_lr),
    .shift_en   (shift_en),
    .sout       (m_so),
    .sout_valid (m_sv),
    .busy       (m_busy),
    .done       (m_done)
  );

  piso_serializer #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (l_lr),
    .shift_en   (shift_en),
    .sout       (l_so),
    .sout_valid (l_sv),
    .busy       (l_busy),
    .done       (l_done)
  );

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%b expected=%b",
             tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    logic b, d, so_m, so_l;
    b    = (qm.size() > 0);
    d    = (qm.size() == 1) && shift_en;
    so_m = b ? qm[0] : 1'b0;
    so_l = b ? ql[0] : 1'b0;
    chk("msb_busy", m_busy, b);
    chk("msb_valid", m_sv, b && shift_en);
    chk("msb_sout", m_so, so_m);
    chk("msb_done", m_done, d);
    chk("msb_ready", m_lr, !b || d);
    chk("lsb_busy", l_busy, b);
    chk("lsb_valid", l_sv, b && shift_en);
    chk("lsb_sout", l_so, so_l);
    chk("lsb_done", l_done, d);
    chk("lsb_ready", l_lr, !b || d);
  endtask

  task automatic model_edge();
    bit rdy;
    if (rst) begin
      qm.delete();
      ql.delete();
    end else begin
      rdy = (qm.size() == 0) || ((qm.size() == 1) && shift_en);
      if ((qm.size() == 1) && shift_en) dones++;
      if (shift_en && (qm.size() > 0)) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (load_valid && rdy) begin
        for (int i = 0; i < N; i++) begin
          qm.push_back(din[N-1-i]);
          ql.push_back(din[i]);
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic lv,
                     input logic [N-1:0] d, input logic se);
    rst        = r;
    load_valid = lv;
    din        = d;
    shift_en   = se;
    @(negedge clk);
    if (!r) check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int d0;
    rst = 1'b1; load_valid = 1'b1;
    din = 8'hFF; shift_en = 1'b1;
    #1;
    cyc(1, 1, 8'hFF, 1);
    cyc(1, 1, 8'hFF, 1);
    cyc(0, 0, 8'hFF, 1);

    cyc(0, 1, 8'b10101010, 1);
    repeat (8) cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    d0 = dones;
    cyc(0, 1, 8'b01010101, 1);
    repeat (8) cyc(0, 1, 8'b11101010, 1);
    repeat (8) cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);
    chk("b2b_done_count", (dones - d0) == 2, 1'b1);

    cyc(0, 1, 8'b01011111, 1);
    repeat (2) cyc(0, 0, 8'h00, 1);
    repeat (3) cyc(0, 0, 8'h00, 0);
    repeat (6) cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    cyc(0, 1, 8'b00010001, 1);
    repeat (8) cyc(0, 0, 8'h00, 1);

    cyc(0, 1, 8'b01111100, 1);
    repeat (4) cyc(0, 0, 8'h00, 1);
    cyc(1, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'b10000000, 1);
    repeat (8) cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 60) == 0),
          $urandom_range(0, 1) == 1,
          N'($urandom),
          $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
